// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl: wide add/subtract sequenced over one shared 4-bit slice
// Optional zero-result flag enabled by defining NIBBLE_ADDSUB_ZERO_FLAG_EN.
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 m,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
`ifdef NIBBLE_ADDSUB_ZERO_FLAG_EN
  output logic                 overflow,
  output logic                 zero
`else
  output logic                 overflow
`endif
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic in_ready_q, in_ready_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic m_q, m_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0] x, bn, y, s, lo;
  logic [1:0] hi;
  logic hit, last, c3, c4;
`ifdef NIBBLE_ADDSUB_ZERO_FLAG_EN
  logic zero_q, zero_d;
`endif
  // pick the active nibble and run it through the XOR-on-B slice, split at bit 3 to expose c3
  always_comb begin
    x = '0;
    bn = '0;
    hit = 1'b0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IW'(n)) begin
        x = a_q[4*n +: 4];
        bn = b_q[4*n +: 4];
        hit = 1'b1;
      end
    end
    y = bn ^ {4{m_q}};
    lo = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, carry_q};
    hi = {1'b0, x[3]} + {1'b0, y[3]} + {1'b0, lo[3]};
    s = {hi[0], lo[2:0]};
  end
  assign c3 = lo[3];
  assign c4 = hi[1];
  assign last = idx_q == IW'(NIBBLES - 1);
  // next-state and datapath updates; idx wraps to 0 after the MSB nibble so it never leaves range
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    carry_d = carry_q;
    idx_d = idx_q;
    result_d = result_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
`ifdef NIBBLE_ADDSUB_ZERO_FLAG_EN
    zero_d = zero_q;
`endif
    case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        a_d = a;
        b_d = b;
        m_d = m;
        carry_d = m;
        idx_d = '0;
`ifdef NIBBLE_ADDSUB_ZERO_FLAG_EN
        zero_d = 1'b1;
`endif
        state_d = RUN;
      end
      RUN: if (!hit) state_d = IDLE;
      else begin
        for (int n = 0; n < NIBBLES; n++)
          if (idx_q == IW'(n)) result_d[4*n +: 4] = s;
        carry_d = c4;
        idx_d = last ? '0 : idx_q + IW'(1);
`ifdef NIBBLE_ADDSUB_ZERO_FLAG_EN
        zero_d = zero_q & (s == 4'h0);
`endif
        if (last) begin
          cout_d = c4;
          ovf_d = c3 ^ c4;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == IDLE;
  end
  // registers; in_ready is registered so it stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      in_ready_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      m_q <= 1'b0;
      carry_q <= 1'b0;
      idx_q <= '0;
      result_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
`ifdef NIBBLE_ADDSUB_ZERO_FLAG_EN
      zero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
      carry_q <= carry_d;
      idx_q <= idx_d;
      result_q <= result_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
`ifdef NIBBLE_ADDSUB_ZERO_FLAG_EN
      zero_q <= zero_d;
`endif
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign carry_out = cout_q;
  assign overflow = ovf_q;
`ifdef NIBBLE_ADDSUB_ZERO_FLAG_EN
  assign zero = zero_q;
`endif
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// tb_nibble_serial_addsub_ctrl: scoreboard bench against an arithmetic reference model
module tb_nibble_serial_addsub_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;
  typedef struct packed {
    logic [W-1:0] r;
    logic c;
    logic o;
    logic z;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, m = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, carry_out, overflow;
  logic [W-1:0] a = '0, b = '0, result;
`ifdef NIBBLE_ADDSUB_ZERO_FLAG_EN
  logic zero;
`endif
  int checks = 0, errors = 0, cyc = 0, rise_cyc = 0, ma;
  exp_t exp_q[$];
  int acc_q[$];
  int acc_log[$];
  exp_t me, bp;
  logic prev_ov = 1'b0;
  bit rand_rdy;

  nibble_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .m(m), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out),
`ifdef NIBBLE_ADDSUB_ZERO_FLAG_EN
    .overflow(overflow), .zero(zero)
`else
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // reference: plain integer arithmetic on the whole operands
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tm);
    longint sa, sb, sr, mx, mn;
    logic [W:0] u;
    sa = longint'($signed(ta));
    sb = longint'($signed(tb));
    sr = tm ? sa - sb : sa + sb;
    mx = (longint'(1) <<< (W - 1)) - 1;
    mn = -(longint'(1) <<< (W - 1));
    u = {1'b0, ta} + {1'b0, tb};
    model.r = tm ? ta - tb : ta + tb;
    model.c = tm ? (ta >= tb) : u[W];
    model.o = (sr > mx) || (sr < mn);
    model.z = model.r == '0;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: pick = '0;
      1: pick = '1;
      2: pick = {1'b1, {(W-1){1'b0}}};
      default: pick = W'($urandom);
    endcase
  endfunction

  // present operands until accepted; leaves in_valid high so callers can chain
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tm, input exp_t e);
    int n = 0;
    @(negedge clk);
    a = ta;
    b = tb;
    m = tm;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept", in_ready, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    acc_log.push_back(cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tm);
    issue(ta, tb, tm, model(ta, tb, tm));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // monitor: pop and compare on every completed output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        chk("pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          me = exp_q.pop_front();
          ma = acc_q.pop_front();
          chk("result", result, me.r);
          chk("carry_out", carry_out, me.c);
          chk("overflow", overflow, me.o);
`ifdef NIBBLE_ADDSUB_ZERO_FLAG_EN
          chk("zero", zero, me.z);
`endif
          chk("latency", rise_cyc - ma, NIBBLES + 1);
        end
      end
    end
    prev_ov = rst_n ? out_valid : 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n0, n;
    bit seen;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", {in_ready, out_valid, result, carry_out, overflow}, 0);
`ifdef NIBBLE_ADDSUB_ZERO_FLAG_EN
    chk("reset_zero", zero, 0);
`endif
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_edge", in_ready, 1);
    // directed vectors with hand-derived expectations
    issue(16'h1234, 16'h0FCD, 1'b0, '{r: 16'h2201, c: 1'b0, o: 1'b0, z: 1'b0});
    issue(16'h0005, 16'h0007, 1'b1, '{r: 16'hFFFE, c: 1'b0, o: 1'b0, z: 1'b0});
    issue(16'h8000, 16'h0001, 1'b1, '{r: 16'h7FFF, c: 1'b1, o: 1'b1, z: 1'b0});
    issue(16'h7FFF, 16'h0001, 1'b0, '{r: 16'h8000, c: 1'b0, o: 1'b1, z: 1'b0});
    issue(16'h0003, 16'h0003, 1'b1, '{r: 16'h0000, c: 1'b1, o: 1'b0, z: 1'b1});
    in_valid = 1'b0;
    drain();
    // backpressure in DONE while new operands are offered
    out_ready = 1'b0;
    a = pick();
    b = pick();
    m = 1'(($urandom_range(0, 1)));
    bp = model(a, b, m);
    issue(a, b, m, bp);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'(($urandom_range(0, 1)));
      a = W'($urandom);
      b = W'($urandom);
      m = 1'(($urandom_range(0, 1)));
      chk("bp_hold", {out_valid, in_ready, result, carry_out, overflow}, {1'b1, 1'b0, bp.r, bp.c, bp.o});
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    send(pick(), pick(), 1'(($urandom_range(0, 1))));
    in_valid = 1'b0;
    drain();
    // asynchronous reset during the second RUN cycle
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'h0001;
    m = 1'b0;
    in_valid = 1'b1;
    chk("midop_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midop_reset_outs", {in_ready, out_valid, result, carry_out, overflow}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midop_in_ready_before_edge", in_ready, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen |= out_valid;
      if (i == 0) chk("midop_in_ready_after_edge", in_ready, 1);
    end
    chk("midop_no_pulse", seen, 0);
    // randomized traffic with random consumer stalls
    rand_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 30; i++) send(pick(), pick(), 1'(($urandom_range(0, 1))));
        in_valid = 1'b0;
        rand_rdy = 1'b0;
      end
      begin
        while (rand_rdy) begin
          @(posedge clk);
          #1 out_ready = 1'(($urandom_range(0, 1)));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    // back-to-back with in_valid and out_ready held high
    n0 = acc_log.size();
    for (int i = 0; i < 3; i++) send(pick(), pick(), 1'(($urandom_range(0, 1))));
    in_valid = 1'b0;
    drain();
    chk("b2b_gap1", acc_log[n0 + 1] - acc_log[n0], NIBBLES + 2);
    chk("b2b_gap2", acc_log[n0 + 2] - acc_log[n0 + 1], NIBBLES + 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_addsub_ctrl.md
Name: nibble_serial_addsub_ctrl

Overview:
- Sequences one shared 4-bit add/subtract slice over NIBBLES cycles to add or subtract wide operands.
- The slice is an XOR-on-B ripple adder with carry-in = M.
- Operands are captured with a valid/ready handshake. The inter-nibble carry is registered, and result, carry and signed overflow are returned with a valid/ready handshake.
- Sits between the operand source and the result consumer, in place of a wide combinational adder.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal values 2..8.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands a, b, m valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A (unsigned or two's complement).
- b  input  W  operand B.
- m  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer accepts result.
- result  output  W  A+B or A-B, modulo 2^W.
- carry_out  output  1  carry out of MSB slice; for subtract, 1 = no borrow (A>=B unsigned).
- overflow  output  1  signed overflow.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- While rst_n=0:
  - state=IDLE.
  - in_ready=0 during reset; 1 from the first edge after release.
  - out_valid=0, result=0, carry_out=0, overflow=0.
  - Internal a_r, b_r, m_r, carry_r and idx are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at the edge: capture a, b, m into a_r, b_r, m_r; set carry_r=m, idx=0; go to RUN.
- RUN:
  - in_ready=0. in_valid is ignored; operands are not latched.
  - Each cycle the slice computes nibble idx: x = a_r[idx], y = b_r[idx] XOR {4{m_r}}, cin = carry_r.
  - {c4, s} = x + y + cin, with c3 = carry into bit 3 of the slice.
  - On the edge: result[idx] <= s, carry_r <= c4, idx <= idx+1.
  - When idx == NIBBLES-1: carry_out <= c4, overflow <= c3 XOR c4, go to DONE.
  - Exactly NIBBLES cycles in RUN.
- DONE:
  - out_valid=1; result, carry_out and overflow are stable.
  - On out_ready=1 at the edge: go to IDLE. out_valid drops the next cycle.
  - Holds indefinitely under backpressure. in_ready=0 here, so a same-cycle in_valid is not accepted until the following IDLE cycle.
- Latency:
  - Accept edge at cycle T; out_valid first high in cycle T+NIBBLES+1.
  - Minimum initiation interval is NIBBLES+2 cycles.
- Output holding:
  - result holds its last value in IDLE.
  - Nibbles are overwritten progressively during RUN; result is only meaningful while out_valid=1.
- Arithmetic:
  - All widths are exact; result wraps modulo 2^W.
  - m=1 implements A + ~B + 1.
- Reset mid-operation (RUN or DONE): immediate return to IDLE with all outputs cleared. The partial result is discarded and no out_valid pulse is produced.
- idx never exceeds NIBBLES-1. Unused idx codes return to IDLE.

Optional Feature:
- Macro: NIBBLE_ADDSUB_ZERO_FLAG_EN.
- When defined:
  - Adds output port zero (1 bit, reset 0), valid with out_valid.
  - zero is 1 iff result == 0.
  - Accumulated per nibble during RUN (zero_r <= zero_r AND (s==0); zero_r set to 1 on accept), so there is no wide compare.
- When undefined: no zero port and no extra logic.

Test Plan:
- NIBBLES=4, a=0x1234, b=0x0FCD, m=0 -> result=0x2201, carry_out=0, overflow=0; out_valid exactly 5 cycles after the accept edge.
- a=0x0005, b=0x0007, m=1 -> result=0xFFFE, carry_out=0 (borrow), overflow=0. Then a=0x8000, b=0x0001, m=1 -> result=0x7FFF, carry_out=1, overflow=1.
- a=0x7FFF, b=0x0001, m=0 -> result=0x8000, carry_out=0, overflow=1. With the macro: a=0x0003, b=0x0003, m=1 -> result=0x0000, zero=1, carry_out=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid with new operands -> out_valid stays 1, result is unchanged, in_ready=0, new operands are not captured. Release out_ready -> IDLE, then the next in_valid is accepted.
- Reset mid-op: accept a=0xFFFF, b=0x0001, m=0; assert rst_n=0 on the 2nd RUN cycle -> all outputs 0 immediately. After release, in_ready=1 and no out_valid pulse occurs.
- Back-to-back: in_valid and out_ready held at 1 with three operand sets -> three results in order, accepts spaced NIBBLES+2 = 6 cycles apart.
